// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: audio link sizing constants shared by i2s_tx and i2s_clkgen, plus counter-width helper.
package i2s_tx_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int SLOT_W_DEF   = 32;
  localparam int CLK_DIV_DEF  = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: divides clk into the I2S bit clock and emits single-clk rise/fall event strobes.
module i2s_clkgen
  import i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic RESET,
  input  logic enable,
  input  logic run,
  output logic bclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int                 DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             active;
  logic             terminal;

  // The divider stays parked at zero on the frame-start clk, so the first rise lands CLK_DIV clks later.
  assign active   = enable && run;
  assign terminal = active && (div_cnt_q == DIV_LAST);
  assign fall_evt = terminal && bclk_q;
  assign rise_evt = terminal && !bclk_q;
  assign bclk     = bclk_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a signal unassigned and no latch is inferred.
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!active) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (terminal) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    if (RESET) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: master-mode I2S serializer latching one stereo pair per frame and requesting the next via new_sample.
// Optional macro I2S_TX_MUTE_EN adds a `mute` input sampled at frame start that loads silence instead.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                enable,
`ifdef I2S_TX_MUTE_EN
  input  logic                mute,
`endif
  input  logic [SAMPLE_W-1:0] in_l,
  input  logic [SAMPLE_W-1:0] in_r,
  output logic                new_sample,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int               CNT_W     = cnt_width(2 * SLOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN  = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(SAMPLE_W);

  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                new_sample_q, new_sample_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                frame_start;
  logic                mute_now;
  logic                fall_evt;
  logic                rise_evt;
  logic                run;

`ifdef I2S_TX_MUTE_EN
  assign mute_now = mute;
`else
  assign mute_now = 1'b0;
`endif

  assign run = (state_q == ST_RUN);

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .RESET    (RESET),
    .enable   (enable),
    .run      (run),
    .bclk     (bclk),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt)
  );

  // Position inside the current channel slot; position 0 is the I2S one-bit-delay padding bit.
  function automatic logic [CNT_W-1:0] slot_pos(input logic [CNT_W-1:0] cnt);
    return (cnt >= SLOT_LEN) ? cnt - SLOT_LEN : cnt;
  endfunction

  function automatic logic is_data(input logic [CNT_W-1:0] pos);
    return (pos != '0) && (pos <= LAST_DATA);
  endfunction

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    shift_d      = shift_q;
    new_sample_d = 1'b0;
    frame_start  = 1'b0;

    if (!enable) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
      hold_l_d  = '0;
      hold_r_d  = '0;
      shift_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d     = ST_RUN;
      bit_cnt_d   = '0;
      lrclk_d     = 1'b0;
      sdata_d     = 1'b0;
      frame_start = 1'b1;
    end else begin
      // Advance the shifter only after the DAC has sampled the current bit on the rising edge.
      if (rise_evt && is_data(slot_pos(bit_cnt_q))) begin
        shift_d = shift_q << 1;
      end
      if (fall_evt) begin
        bit_cnt_d   = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
        frame_start = (bit_cnt_q == CNT_LAST);
        lrclk_d     = (bit_cnt_d >= SLOT_LEN);
        sdata_d     = is_data(slot_pos(bit_cnt_d)) && shift_q[SAMPLE_W-1];
        if (bit_cnt_d == SLOT_LEN) begin
          shift_d = hold_r_q;
        end
      end
    end

    if (frame_start) begin
      hold_l_d     = mute_now ? '0 : in_l;
      hold_r_d     = mute_now ? '0 : in_r;
      shift_d      = hold_l_d;
      new_sample_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      new_sample_q <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      shift_q      <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      new_sample_q <= new_sample_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      shift_q      <= shift_d;
    end
  end

  assign new_sample = new_sample_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;

endmodule
